// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one full-adder
// cell with a carry flip-flop; the registered result updates once per operation.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sr, b_sr, ps;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               s_bit, c_nxt, last, load;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  always_comb begin
    s_bit = fa_sum(a_sr[0], b_sr[0], carry);
    c_nxt = fa_carry(a_sr[0], b_sr[0], carry);
    last  = (cnt == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Bit-serial datapath; sum/cout only move on the final shift edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      ps    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      carry <= c_nxt;
      ps    <= {s_bit, ps[WIDTH-1:1]};
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= {s_bit, ps[WIDTH-1:1]};
        cout <= c_nxt;
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=4, using an
// arithmetic reference ({cout,sum} = a + b + cin) and cycle-count checks.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done;
  logic [7:0] sum;
  logic       cout;

  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy4, done4;
  logic [3:0] sum4;
  logic       cout4;

  int n_chk  = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge inside the done cycle.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tc, input int poke_at);
    logic [8:0] exp;
    logic [7:0] prev_sum;
    logic       prev_cout;
    logic       stable;
    int         nb;
    exp       = {1'b0, ta} + {1'b0, tb_} + {8'd0, tc};
    prev_sum  = sum;
    prev_cout = cout;
    stable    = 1'b1;
    start = 1'b1; a = ta; b = tb_; cin = tc;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    nb = 0;
    while (busy && nb < 40) begin
      if (sum !== prev_sum || cout !== prev_cout || done !== 1'b0) stable = 1'b0;
      if (nb == poke_at) begin
        start = 1'b1; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      nb++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " busy_cycles"}, 32'(nb), 32'd8);
    chk({tag, " hold_during_shift"}, 32'(stable), 32'd1);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " sum"}, 32'(sum), 32'(exp[7:0]));
    chk({tag, " cout"}, 32'(cout), 32'(exp[8]));
  endtask

  task automatic idle_after(input string tag);
    @(negedge clk);
    chk({tag, " done_dropped"}, 32'(done), 32'd0);
    chk({tag, " busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [4:0] exp4;
    int         nb;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    chk("reset4 sum", 32'(sum4), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("op35_4a", 8'h35, 8'h4A, 1'b0, -1); idle_after("op35_4a");
    run_op("opff_01", 8'hFF, 8'h01, 1'b0, -1); idle_after("opff_01");
    run_op("opff_ff", 8'hFF, 8'hFF, 1'b1, -1); idle_after("opff_ff");
    run_op("ignore",  8'h10, 8'h20, 1'b0, 2);  idle_after("ignore");

    run_op("b2b_first",  8'h01, 8'h02, 1'b0, -1);
    run_op("b2b_second", 8'h80, 8'h80, 1'b0, -1);
    idle_after("b2b_second");

    run_op("op0f_01", 8'h0F, 8'h01, 1'b0, -1); idle_after("op0f_01");

    start = 1'b1; a = 8'h0F; b = 8'h0F; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort sum", 32'(sum), 32'd0);
    chk("abort cout", 32'(cout), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    @(negedge clk);
    chk("abort hold done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort no_late_done", 32'(done), 32'd0);
    run_op("after_reset", 8'hA7, 8'h3C, 1'b1, -1); idle_after("after_reset");

    for (int i = 0; i < 8; i++) begin
      run_op("random", 8'($urandom), 8'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
      if ($urandom_range(0, 1) == 1) idle_after("random");
    end
    idle_after("random_tail");

    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1;
      end else begin
        a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      end
      exp4 = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
      start4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start4 = 1'b0;
      nb = 0;
      while (busy4 && nb < 40) begin
        nb++;
        @(negedge clk);
      end
      chk("w4 busy_cycles", 32'(nb), 32'd4);
      chk("w4 done", 32'(done4), 32'd1);
      chk("w4 sum", 32'(sum4), 32'(exp4[3:0]));
      chk("w4 cout", 32'(cout4), 32'(exp4[4]));
      @(negedge clk);
      chk("w4 done_dropped", 32'(done4), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder. It is the inverse-direction companion to the team's full-subtractor blocks.
- Parallel operands are loaded on a start handshake and processed LSB-first through a single full-adder cell with a carry flip-flop, one bit per clock.
- Presents the registered sum, carry-out and a one-cycle done pulse.
- Intended as the arithmetic back end for add/subtract-check datapaths, where area matters more than latency.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising clk edge, accepted only when busy=0
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  single-cycle pulse: result registers just updated
sum  output  WIDTH  last completed sum, registered
cout  output  1  last completed carry-out, registered

Behaviour:
- Reset: rst_n low forces outputs immediately, without waiting for clk.
  - Outputs: busy=0, done=0, sum=0, cout=0.
  - Internal state: IDLE, carry FF=0, bit counter=0, operand shift registers=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: load a, b into shift registers, load carry FF with cin, clear counter, go to SHIFT.
- SHIFT:
  - busy=1.
  - Each edge computes s = a_sr[0] ^ b_sr[0] ^ c and c_next = majority(a_sr[0], b_sr[0], c).
  - s is shifted into the MSB of the partial-sum register; a_sr and b_sr shift right by one; counter increments.
  - On the edge where counter = WIDTH-1 (the WIDTH-th SHIFT edge), copy the completed partial sum to sum and c_next to cout, then go to DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - On the next edge: if start=1, accept the new operation (same load as in IDLE) and go to SHIFT; otherwise go to IDLE.
- Latency: start accepted at edge E0 → busy=1 during cycles E0..E0+WIDTH. sum/cout update at edge E0+WIDTH and done is high from E0+WIDTH to E0+WIDTH+1. Back-to-back throughput is one result per WIDTH+1 cycles.
- sum and cout are stable except at the completion edge. During SHIFT they hold the previous result; partial bits are never visible on the outputs.
- start while busy=1 is ignored. It is neither queued nor allowed to corrupt the in-flight operands. a, b and cin may change freely after the accept edge.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- Reset mid-operation aborts the operation: no done pulse, and sum/cout return to 0.
- start=1 held continuously yields repeated operations, each re-sampling a, b and cin at its accept edge.

Test Plan:
- WIDTH=8; after reset, check busy=0, done=0, sum=0x00, cout=0. Then start with a=0x35, b=0x4A, cin=0 → busy high 8 cycles, done pulse at E0+8, sum=0x7F, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1. Both complete in 8 busy cycles.
- Start a=0x10, b=0x20. Pulse start again at E0+3 with a=0xAA, b=0x55 → second start ignored; result sum=0x30, cout=0, exactly one done pulse.
- Assert start during the done cycle of a=0x01 + b=0x02 (result 0x03), with new operands a=0x80, b=0x80 → no idle cycle between operations; next done after 8 more busy cycles with sum=0x00, cout=1.
- Complete a=0x0F + b=0x01 (sum=0x10). Start a=0x0F, b=0x0F, then drop rst_n at E0+4 (asynchronously, mid-cycle) → busy=0 and sum=0x00 immediately; no done pulse. A fresh operation afterwards completes correctly.
- Re-run with WIDTH=4: a=0x9, b=0x8, cin=1 → done at E0+4, sum=0x2, cout=1.
